sram_lsu: RTL and testbench
===========================

Name: sram_lsu

Overview:
Load/store initiator that drives the single-port data SRAM interface (csb/web/wmask/addr/din/dout) on behalf of the core pipeline.
- Accepts one load or store at a time over a valid/ready request channel.
- Checks alignment and range, generates SRAM byte-lane strobes, and waits out the SRAM's registered-input read latency.
- Returns sign- or zero-extended load data, or a store acknowledge, on a single-cycle response pulse.
- Sits between the core's memory stage and the data SRAM.

Parameters:
- ADDR_WIDTH, 13, SRAM byte-address width; requests with req_addr >= 2**ADDR_WIDTH are out of range.
- DATA_WIDTH, 32, data width; fixed at 32, 4 byte lanes.
- RD_LATENCY, 2, clock edges from the end of the SRAM issue cycle until sram_dout is safe to sample.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  single-cycle response pulse
- resp_err  out  1  qualified by resp_valid: misaligned, illegal size, or out of range
- resp_rdata  out  32  qualified by resp_valid: extended load data; 0 for stores and errors
- sram_csb  out  1  SRAM read select, active high
- sram_web  out  1  SRAM write enable, active high
- sram_wmask  out  4  byte-lane write mask
- sram_addr  out  ADDR_WIDTH  SRAM byte address
- sram_din  out  32  SRAM write data
- sram_dout  in  32  SRAM read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: all outputs registered. req_ready=1 after reset release. resp_valid=0, resp_err=0, resp_rdata=0. All sram_* outputs 0.
- Idle SRAM drive: sram_web and sram_csb are 0 in every cycle except ISSUE. The SRAM writes whenever web is high, so web must never float high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at an edge (the accept edge, edge 0), latch the request.
  - Error check: size==3; size==1 with addr[0]!=0; size==2 with addr[1:0]!=0; or addr >= 2**ADDR_WIDTH.
  - Error -> RESP in cycle 0 with resp_err=1. No SRAM access occurs.
  - Otherwise -> ISSUE.
- ISSUE (cycle 0, exactly one cycle): sram_addr = req_addr[ADDR_WIDTH-1:0].
  - Store: sram_web=1, sram_csb=0.
    - wmask = 0001 (byte), 0011 (half), 1111 (word).
    - sram_din = wdata with unused upper lanes zeroed.
    - Next state RESP: resp_valid in cycle 1.
  - Load: sram_csb=1, sram_web=0, wmask=0000, din=0. Next state WAIT; load the latency counter with RD_LATENCY-1.
- WAIT: decrement the counter each cycle. Sample sram_dout at edge 1+RD_LATENCY into resp_rdata, extending bits [7:0] or [15:0] per size and req_unsigned. Next state RESP.
  - RD_LATENCY=2 gives resp_valid in cycle 3.
- RESP: resp_valid=1 for exactly one cycle; no backpressure. Next state IDLE, with req_ready=1 the following cycle.
  - Minimum request spacing: error 2 cycles, store 3, load RD_LATENCY+3.
- req_ready: 0 in ISSUE, WAIT and RESP. req_valid is ignored in those states.
- req_* inputs: sampled only at the accept edge. Changes after acceptance have no effect.
- Reset mid-operation: asynchronously returns to IDLE and clears all outputs. An in-flight load is dropped with no response.
  - A store whose ISSUE cycle was cut short may or may not have landed in the SRAM. This is not guaranteed.

Decomposition:
- Shared package lsu_pkg holds:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - The state enum lsu_state_t.
  - The wmask function from size.
- One natural sub-module, lsu_load_ext: combinational byte/half/word sign/zero extension, also reused by the core writeback stage.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles and release.
  -> req_ready=1, resp_valid=0, sram_web=0, sram_csb=0; no SRAM activity for 10 idle cycles.
- Store word 0xDEADBEEF at 0x0100, then LW 0x0100.
  -> Store ISSUE drives web=1, wmask=1111, din=0xDEADBEEF, and resp_valid comes 1 cycle after ISSUE.
  -> Load resp_valid arrives 3 cycles after its accept edge with resp_rdata=0xDEADBEEF, resp_err=0.
- SB 0xA5 at 0x0203, then LB and LBU at 0x0203.
  -> SB issues wmask=0001, din=0x000000A5.
  -> LB returns 0xFFFFFFA5; LBU returns 0x000000A5.
- Error cases: LW 0x0102, SH 0x0011, LW 0x2000 (out of range for ADDR_WIDTH=13), req_size=3.
  -> Each gives resp_valid with resp_err=1 and resp_rdata=0 in cycle 0.
  -> sram_csb and sram_web stay 0 throughout.
- Back-to-back: hold req_valid high continuously with alternating SW/LW.
  -> Exactly one accept per req_ready window; no overlapping SRAM issues; each LW returns the data of the preceding SW.
- Reset mid-WAIT: assert rst_n=0 one cycle after a load's ISSUE.
  -> Outputs clear immediately; no resp_valid for that load; the next LW completes normally.

Source files
------------

// File: rtl/sram_lsu_pkg.sv
// Shared definitions for the data-SRAM load/store unit: size encodings, FSM states,
// and the byte-lane mask helper.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    // Store data is right-justified, so lanes always fill from lane 0 upward.
    function automatic logic [3:0] size_wmask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_wmask = 4'b0001;
            SZ_HALF: size_wmask = 4'b0011;
            SZ_WORD: size_wmask = 4'b1111;
            default: size_wmask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/sram_lsu_if.sv
// Core request/response channel plus data-SRAM port of the load/store unit.
interface sram_lsu_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;
    logic                  sram_csb;
    logic                  sram_web;
    logic [3:0]            sram_wmask;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_din;
    logic [31:0]           sram_dout;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, sram_dout,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, sram_dout,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output sram_csb, sram_web, sram_wmask, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_lsu_load_ext.sv
// Byte/half/word sign or zero extension of right-justified load data.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);
    always_comb begin
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & data_i[7]}}, data_i[7:0]};
            SZ_HALF: data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end
endmodule

// File: rtl/sram_lsu.sv
// Single-outstanding load/store initiator for the single-port data SRAM.
// Every output is registered; web/csb can only be high during ISSUE.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | one-cycle SRAM access (store write or load read select)
// WAIT  | counting out SRAM read latency
// RESP  | one-cycle response pulse
module sram_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    sram_lsu_if.slave bus
);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    lsu_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  ready_q, ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d, din_q, din_d;
    logic                  csb_q, csb_d, web_q, web_d;
    logic [3:0]            wmask_q, wmask_d, lane_m;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;

    logic                  accept, acc_err;
    logic [DATA_WIDTH-1:0] ext_data;

    lsu_load_ext u_ext (
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .data_i    (bus.sram_dout),
        .data_o    (ext_data)
    );

    assign accept  = (state_q == ST_IDLE) && bus.req_valid;
    assign acc_err = (bus.req_size == 2'd3)
                   | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                   | ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0]))
                   | (|bus.req_addr[31:ADDR_WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= SZ_BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            csb_q        <= 1'b0;
            web_q        <= 1'b0;
            wmask_q      <= '0;
            sram_addr_q  <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            err_q        <= err_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            wmask_q      <= wmask_d;
            sram_addr_q  <= sram_addr_d;
            din_q        <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    uns_d   = bus.req_unsigned;
                    err_d   = acc_err;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr[ADDR_WIDTH-1:0];
                    wdata_d = bus.req_wdata;
                    state_d = acc_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so they land registered in that state.
    always_comb begin
        lane_m       = size_wmask(size_d);
        ready_d      = (state_d == ST_IDLE);
        csb_d        = (state_d == ST_ISSUE) && !we_d;
        web_d        = (state_d == ST_ISSUE) && we_d;
        wmask_d      = web_d ? lane_m : 4'b0000;
        sram_addr_d  = (state_d == ST_ISSUE) ? addr_d : '0;
        din_d        = web_d ? (wdata_d & {{8{lane_m[3]}}, {8{lane_m[2]}}, {8{lane_m[1]}}, {8{lane_m[0]}}})
                             : '0;
        resp_valid_d = (state_d == ST_RESP);
        resp_err_d   = resp_valid_d && err_d;
        resp_rdata_d = ((state_q == ST_WAIT) && (state_d == ST_RESP)) ? ext_data : '0;
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.sram_csb   = csb_q;
    assign bus.sram_web   = web_q;
    assign bus.sram_wmask = wmask_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_din   = din_q;

endmodule

// File: tb/tb_sram_lsu.sv
// Scoreboard bench for sram_lsu: a byte-array reference model predicts every SRAM issue
// and response; independent monitors compare them as the DUT presents them.
module tb_sram_lsu;
    import lsu_pkg::*;

    localparam int AW    = 13;
    localparam int MSIZE = 1 << AW;
    localparam int RDL   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_lsu_if #(.ADDR_WIDTH(AW)) bus ();

    sram_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RD_LATENCY(RDL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct { int cyc; logic err; logic [31:0] rdata; } resp_t;
    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [3:0] wmask; logic [31:0] din; } iss_t;

    resp_t rq[$];
    iss_t  iq[$];
    int    cyc     = 0;
    int    n_checks = 0;
    int    n_fail   = 0;

    logic [7:0]  sram_mem [0:MSIZE-1];
    logic [7:0]  ref_mem  [0:MSIZE-1];
    logic [31:0] rd_pipe = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered inputs, data appears two edges after the select edge.
    always @(posedge clk) begin
        if (bus.sram_web)
            for (int i = 0; i < 4; i++)
                if (bus.sram_wmask[i]) sram_mem[(int'(bus.sram_addr) + i) % MSIZE] <= bus.sram_din[8*i +: 8];
        if (bus.sram_csb)
            rd_pipe <= {sram_mem[(int'(bus.sram_addr) + 3) % MSIZE], sram_mem[(int'(bus.sram_addr) + 2) % MSIZE],
                        sram_mem[(int'(bus.sram_addr) + 1) % MSIZE], sram_mem[int'(bus.sram_addr)]};
        bus.sram_dout <= rd_pipe;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        iss_t  e;
        resp_t r;
        if (rst_n) begin
            if (bus.sram_csb || bus.sram_web) begin
                if (iq.size() == 0) begin
                    chk("unexpected_sram_issue", {30'b0, bus.sram_csb, bus.sram_web}, 32'h0);
                end else begin
                    e = iq.pop_front();
                    chk("issue_cycle", cyc, e.cyc);
                    chk("issue_csb", bus.sram_csb, !e.we);
                    chk("issue_web", bus.sram_web, e.we);
                    chk("issue_addr", bus.sram_addr, e.addr);
                    chk("issue_wmask", bus.sram_wmask, e.wmask);
                    chk("issue_din", bus.sram_din, e.din);
                end
            end
            if (bus.resp_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_resp", bus.resp_valid, 32'h0);
                end else begin
                    r = rq.pop_front();
                    chk("resp_cycle", cyc, r.cyc);
                    chk("resp_err", bus.resp_err, r.err);
                    chk("resp_rdata", bus.resp_rdata, r.rdata);
                end
            end
        end
    end

    // Reference model: predicts SRAM traffic and response for a request accepted at edge a.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int a);
        resp_t r;
        iss_t  s;
        int    n;
        logic  err;
        logic [31:0] v, lanes;
        n   = 1 << sz;
        err = (sz == 2'd3) || (addr % n != 0) || (addr >= MSIZE);
        if (err) begin
            r.cyc = a; r.err = 1'b1; r.rdata = 32'h0;
            rq.push_back(r);
            return;
        end
        lanes = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        s.cyc = a; s.we = we; s.addr = addr[AW-1:0];
        if (we) begin
            s.wmask = 4'((1 << n) - 1);
            s.din   = wd & lanes;
            for (int i = 0; i < n; i++) ref_mem[(addr + i) % MSIZE] = wd[8*i +: 8];
            r.cyc = a + 1; r.err = 1'b0; r.rdata = 32'h0;
        end else begin
            s.wmask = 4'b0;
            s.din   = 32'h0;
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v + (32'(ref_mem[(addr + i) % MSIZE]) << (8 * i));
            if (!uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
            r.cyc = a + 1 + RDL; r.err = 1'b0; r.rdata = v;
        end
        iq.push_back(s);
        rq.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with req_valid still high.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int waited = 0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", {31'b0, bus.req_ready}, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        model(we, sz, uns, addr, wd, cyc + 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        bus.req_we = 1'($urandom); bus.req_size = 2'($urandom); bus.req_unsigned = 1'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_req();
        logic [1:0]  sz;
        logic [31:0] addr;
        int          k;
        k  = $urandom_range(0, 19);
        sz = 2'($urandom_range(0, 2));
        addr = 32'h100 + 32'($urandom_range(0, 15) * 4);
        if (sz == SZ_BYTE)      addr = addr + 32'($urandom_range(0, 3));
        else if (sz == SZ_HALF) addr = addr + 32'(2 * $urandom_range(0, 1));
        if (k == 0) sz = 2'd3;
        if (k == 1) begin sz = SZ_WORD; addr = addr | 32'($urandom_range(1, 3)); end
        if (k == 2) addr = 32'h2000 | ($urandom & 32'hFFFF_FFFC);
        do_req(1'($urandom), sz, 1'($urandom), addr, $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        for (int i = 0; i < MSIZE; i++) begin
            sram_mem[i] = 8'h0;
            ref_mem[i]  = 8'h0;
        end
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", bus.req_ready, 32'h1);
        chk("reset_resp_err", bus.resp_err, 32'h0);
        chk("reset_resp_rdata", bus.resp_rdata, 32'h0);
        chk("reset_sram_addr", bus.sram_addr, 32'h0);
        chk("reset_sram_din", bus.sram_din, 32'h0);
        chk("reset_sram_wmask", bus.sram_wmask, 32'h0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_quiet", {29'b0, bus.sram_csb, bus.sram_web, bus.resp_valid}, 32'h0);
            @(negedge clk);
        end

        do_req(1'b1, SZ_WORD, 1'b0, 32'h0100, 32'hDEAD_BEEF);
        idle(0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h0100, 32'h0);
        idle(6);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h0203, 32'h1234_56A5);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h0203, 32'h0);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h0203, 32'h0);
        idle(6);

        do_req(1'b0, SZ_WORD, 1'b0, 32'h0102, 32'h0);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h0011, 32'hFFFF_FFFF);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h2000, 32'h0);
        do_req(1'b1, 2'd3,    1'b0, 32'h0100, 32'hFFFF_FFFF);
        idle(4);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'h300 + 32'($urandom_range(0, 31) * 4);
            do_req(1'b1, SZ_WORD, 1'b0, a, $urandom);
            do_req(1'b0, SZ_WORD, 1'b0, a, 32'h0);
        end
        idle(6);

        for (int i = 0; i < 200; i++) begin
            rand_req();
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end
        idle(8);

        do_req(1'b0, SZ_WORD, 1'b0, 32'h0100, 32'h0);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {28'b0, bus.resp_valid, bus.resp_err, bus.sram_csb, bus.sram_web}, 32'h0);
        chk("midreset_rdata", bus.resp_rdata, 32'h0);
        chk("midreset_wmask", bus.sram_wmask, 32'h0);
        rq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h0100, 32'h0);
        idle(0);

        waited = 0;
        while ((rq.size() != 0 || iq.size() != 0) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_resp_queue", rq.size(), 32'h0);
        chk("drain_issue_queue", iq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
